// File: rtl/mem_arbiter2.sv
// mem_arbiter2: round-robin arbiter sharing one memory port between fetch (m0) and load/store (m1)
module mem_arbiter2 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_m0_req,
  input  logic [ADDR_WIDTH-1:0] i_m0_addr,
  input  logic                  i_m0_we,
  input  logic [DATA_WIDTH-1:0] i_m0_wdata,
  output logic                  o_m0_ack,
  output logic [DATA_WIDTH-1:0] o_m0_rdata,
  input  logic                  i_m1_req,
  input  logic [ADDR_WIDTH-1:0] i_m1_addr,
  input  logic                  i_m1_we,
  input  logic [DATA_WIDTH-1:0] i_m1_wdata,
  output logic                  o_m1_ack,
  output logic [DATA_WIDTH-1:0] o_m1_rdata,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_owner,
  output logic                  o_busy
);
  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;
  state_t                  state_q, state_d;
  logic                    last_q, last_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    take, grant;
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    take    = 1'b0;
    grant   = 1'b0;
    if (state_q == IDLE) begin
      take  = i_m0_req | i_m1_req;
      grant = (i_m0_req & i_m1_req) ? ~last_q : i_m1_req;
    end else if (i_mem_ack) begin
      // on the ack cycle only the other master may be handed the port
      grant   = (state_q == BUSY0);
      take    = grant ? i_m1_req : i_m0_req;
      state_d = IDLE;
    end
    if (take) begin
      state_d = grant ? BUSY1 : BUSY0;
      last_d  = grant;
      addr_d  = grant ? i_m1_addr : i_m0_addr;
      we_d    = grant ? i_m1_we : i_m0_we;
      wdata_d = grant ? i_m1_wdata : i_m0_wdata;
    end
  end
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end
  assign o_busy      = (state_q != IDLE);
  assign o_mem_req   = o_busy;
  assign o_mem_addr  = addr_q;
  assign o_mem_we    = we_q;
  assign o_mem_wdata = wdata_q;
  assign o_owner     = last_q;
  assign o_m0_ack    = (state_q == BUSY0) & i_mem_ack;
  assign o_m1_ack    = (state_q == BUSY1) & i_mem_ack;
  assign o_m0_rdata  = o_m0_ack ? i_mem_rdata : '0;
  assign o_m1_rdata  = o_m1_ack ? i_mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter2.sv
// tb_mem_arbiter2: directed scenarios plus randomized traffic checked against a transaction-level model
module tb_mem_arbiter2;
  logic        i_clock;
  logic        i_reset;
  logic [1:0]  req;
  logic [31:0] addr [2];
  logic [1:0]  we;
  logic [31:0] wdata [2];
  logic [1:0]  ack;
  logic [31:0] rdata [2];
  logic        o_mem_req, o_mem_we, o_owner, o_busy;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  int          tests = 0;
  int          fails = 0;

  mem_arbiter2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_m0_req(req[0]), .i_m0_addr(addr[0]), .i_m0_we(we[0]), .i_m0_wdata(wdata[0]),
    .o_m0_ack(ack[0]), .o_m0_rdata(rdata[0]),
    .i_m1_req(req[1]), .i_m1_addr(addr[1]), .i_m1_we(we[1]), .i_m1_wdata(wdata[1]),
    .o_m1_ack(ack[1]), .o_m1_rdata(rdata[1]),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_owner(o_owner), .o_busy(o_busy)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who holds the port (if anyone) and the captured request of that transaction
  bit          m_busy, m_last;
  logic [31:0] m_addr, m_wdata;
  logic        m_we;
  bit   [1:0]  m_ack, ack_seen;

  task automatic give(input bit g);
    m_busy  = 1;
    m_last  = g;
    m_addr  = addr[g];
    m_we    = we[g];
    m_wdata = wdata[g];
  endtask

  always @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      m_busy = 0; m_last = 1; m_addr = 0; m_we = 0; m_wdata = 0;
    end else if (!m_busy) begin
      if (req == 2'b11) give(!m_last);
      else if (req != 2'b00) give(req[1]);
    end else if (i_mem_ack) begin
      if (req[!m_last]) give(!m_last);
      else m_busy = 0;
    end
  end

  always @(negedge i_clock) begin
    if (!i_reset) begin
      for (int n = 0; n < 2; n++) m_ack[n] = m_busy && (m_last == n) && i_mem_ack;
      check("mem_req", o_mem_req, m_busy);
      check("busy", o_busy, m_busy);
      check("owner", o_owner, m_last);
      check("mem_addr", o_mem_addr, m_addr);
      check("mem_we", o_mem_we, m_we);
      check("mem_wdata", o_mem_wdata, m_wdata);
      for (int n = 0; n < 2; n++) begin
        check($sformatf("ack%0d", n), ack[n], m_ack[n]);
        if (m_ack[n]) check($sformatf("rdata%0d", n), rdata[n], i_mem_rdata);
        else if (m_busy && m_last != n) check($sformatf("rdata%0d_idle", n), rdata[n], 0);
      end
      ack_seen = m_ack;
    end
  end

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mem_req"}, o_mem_req, 0);
    check({tag, "_addr"}, o_mem_addr, 0);
    check({tag, "_we"}, o_mem_we, 0);
    check({tag, "_wdata"}, o_mem_wdata, 0);
    check({tag, "_owner"}, o_owner, 1);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_acks"}, ack, 0);
    check({tag, "_rdata0"}, rdata[0], 0);
    check({tag, "_rdata1"}, rdata[1], 0);
  endtask

  initial begin
    i_reset = 0; req = 0; we = 0; i_mem_ack = 0; i_mem_rdata = 0;
    addr[0] = 0; addr[1] = 0; wdata[0] = 0; wdata[1] = 0;
    #2 i_reset = 1;
    tick(); tick();
    i_reset = 0;
    @(negedge i_clock) check_reset_vals("rst");
    // single m0 read
    tick();
    req[0] = 1; addr[0] = 32'h100;
    @(negedge i_clock) check("t1_pre_busy", o_busy, 0);
    tick();
    @(negedge i_clock) begin
      check("t1_req", o_mem_req, 1);
      check("t1_addr", o_mem_addr, 32'h100);
      check("t1_owner", o_owner, 0);
    end
    tick();
    @(negedge i_clock) check("t1_noack", ack[0], 0);
    tick();
    i_mem_ack = 1; i_mem_rdata = 32'hDEADBEEF;
    @(negedge i_clock) begin
      check("t1_ack0", ack[0], 1);
      check("t1_rdata0", rdata[0], 32'hDEADBEEF);
      check("t1_ack1", ack[1], 0);
    end
    tick();
    req[0] = 0; i_mem_ack = 0;
    @(negedge i_clock) check("t1_idle", o_busy, 0);
    // contention, both held, single-cycle memory: grants alternate from m0
    i_reset = 1; #1 i_reset = 0;
    tick();
    req = 2'b11; i_mem_ack = 1; addr[1] = 32'h400;
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clock) begin
        check($sformatf("t2_owner%0d", k), o_owner, k % 2);
        check($sformatf("t2_req%0d", k), o_mem_req, 1);
        check($sformatf("t2_ack%0d", k), ack[k % 2], 1);
      end
      tick();
      if (k == 2) req[0] = 0;
    end
    req[1] = 0; i_mem_ack = 0;
    @(negedge i_clock) check("t2_idle", o_busy, 0);
    // m1 write, fields change mid-transaction
    req[1] = 1; we[1] = 1; addr[1] = 32'h200; wdata[1] = 32'h55AA;
    tick();
    addr[1] = 32'h300; wdata[1] = 32'h1234;
    for (int k = 0; k < 2; k++) begin
      @(negedge i_clock) begin
        check("t3_addr", o_mem_addr, 32'h200);
        check("t3_wdata", o_mem_wdata, 32'h55AA);
        check("t3_we", o_mem_we, 1);
      end
      tick();
    end
    i_mem_ack = 1;
    @(negedge i_clock) begin
      check("t3_ack1", ack[1], 1);
      check("t3_addr_ack", o_mem_addr, 32'h200);
    end
    tick();
    req[1] = 0; i_mem_ack = 0; we[1] = 0;
    // m0 alone and continuous: IDLE between transactions
    req[0] = 1;
    i_mem_ack = 1;
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clock) begin
        check($sformatf("t4_busy%0d", k), o_busy, (k % 2 == 0));
        check($sformatf("t4_owner%0d", k), o_owner, 0);
      end
      tick();
      if (k == 2) req[0] = 0;
    end
    i_mem_ack = 0;
    // reset in BUSY1, then late ack
    req[1] = 1;
    tick();
    check("t5_busy1", o_busy, 1);
    #1 i_reset = 1;
    #1 check_reset_vals("t5");
    req[1] = 0; i_mem_ack = 1; i_reset = 0;
    @(negedge i_clock) begin
      check("t5_ack1", ack[1], 0);
      check("t5_busy", o_busy, 0);
    end
    tick();
    @(negedge i_clock) begin
      check("t6_acks", ack, 0);
      check("t6_busy", o_busy, 0);
    end
    tick();
    i_mem_ack = 0;
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 299) == 0) begin
        req = 0;
        i_reset = 1;
        #1 i_reset = 0;
      end else begin
        for (int n = 0; n < 2; n++) begin
          if (req[n] && ack_seen[n]) req[n] = 1'($urandom_range(0, 1));
          else if (!req[n]) req[n] = ($urandom_range(0, 2) == 0);
          if ($urandom_range(0, 3) == 0) begin
            addr[n] = $urandom; we[n] = 1'($urandom_range(0, 1)); wdata[n] = $urandom;
          end
        end
        i_mem_ack = 1'($urandom_range(0, 1));
        i_mem_rdata = $urandom;
      end
    end
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter2.md
# mem_arbiter2

Two-master arbiter for the single memory port of the RISC-V core. It shares the port between master 0 (instruction fetch) and master 1 (load/store unit) using round-robin priority, and owns the select of the 2:1 address/data selector feeding the port. It latches the winning master's request fields, so the port sees stable values for the whole transaction. It routes the memory acknowledge back to the owning master only.

## Interface
Parameters:
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data bus width

Ports (name, direction, width, meaning):
- i_clock, in, 1, clock; all state updates on the rising edge
- i_reset, in, 1, reset, asynchronous, active-high
- i_m0_req, in, 1, master 0 request; held high until o_m0_ack
- i_m0_addr, in, ADDR_WIDTH, master 0 address
- i_m0_we, in, 1, master 0 write enable
- i_m0_wdata, in, DATA_WIDTH, master 0 write data
- o_m0_ack, out, 1, master 0 transaction complete (one-cycle pulse)
- o_m0_rdata, out, DATA_WIDTH, master 0 read data; valid while o_m0_ack=1
- i_m1_req, i_m1_addr, i_m1_we, i_m1_wdata, o_m1_ack, o_m1_rdata: same as master 0, for master 1
- o_mem_req, out, 1, memory transaction active
- o_mem_addr, out, ADDR_WIDTH, latched address
- o_mem_we, out, 1, latched write enable
- o_mem_wdata, out, DATA_WIDTH, latched write data
- i_mem_ack, in, 1, memory completion; sampled only while o_mem_req=1
- i_mem_rdata, in, DATA_WIDTH, memory read data, valid with i_mem_ack
- o_owner, out, 1, current/last owner (0 or 1)
- o_busy, out, 1, high in BUSY0/BUSY1

## Operation
- FSM states are IDLE, BUSY0 and BUSY1. Reset state is IDLE.
- Register `last` records the most recently granted master. Its reset value is 1, so master 0 wins the first contention.
- Grant decision, evaluated in IDLE and on the ack cycle:
  - Only one requester: grant that master.
  - Both requesting: grant the master that is not `last`.
- IDLE with a request:
  - Latch the grantee's addr/we/wdata through the 2:1 selector (select = grantee).
  - Set `last` and o_owner to the grantee.
  - Go to BUSYn.
- BUSYn, i_mem_ack=0: hold state and the latched fields.
- BUSYn, i_mem_ack=1:
  - o_mn_ack=1 and o_mn_rdata=i_mem_rdata, combinationally, in the same cycle.
  - If the other master requests, grant it directly: latch its fields, go to BUSYother.
  - Otherwise go to IDLE.
  - The acked master's request is ignored in the ack cycle, since its req is still legally high.
- o_mx_rdata for the non-owner is 0. o_mx_ack is never asserted outside the owner's BUSY state.
- A master dropping req before its ack is a protocol violation. The latched transaction still completes and the ack is still pulsed.
- i_mem_ack in IDLE is ignored: no ack pulse, no state change.
- Reset mid-transaction:
  - Return to IDLE immediately.
  - The in-flight transaction is abandoned and no ack is delivered for it.
  - A late i_mem_ack after reset falls under the IDLE rule.

## Timing
- Reset values: o_mem_req=0, o_mem_addr=0, o_mem_we=0, o_mem_wdata=0, o_owner=1, o_busy=0, o_m0_ack=0, o_m1_ack=0, o_m0_rdata=0, o_m1_rdata=0.
- o_mem_req, o_mem_addr/we/wdata, o_owner and o_busy are registered outputs.
- Grant latency: request sampled in IDLE at edge N gives o_mem_req=1 from cycle N+1.
- Ack path is zero latency: o_mn_ack coincides with i_mem_ack.
- Back-to-back, opposite masters:
  - o_mem_req stays high across the ack edge.
  - The new fields appear in the cycle after the ack.
- Same master repeating: passes through IDLE for one cycle, so at most one transaction per 2 cycles per master.
- Single-cycle memory (ack in first BUSY cycle): each transaction occupies exactly one BUSY cycle.

## Test plan
- Reset, then m0 req addr=0x100 we=0, memory acks 2 cycles later with rdata=0xDEADBEEF:
  - o_mem_req rises 1 cycle after req, with o_mem_addr=0x100.
  - o_m0_ack=1 and o_m0_rdata=0xDEADBEEF in the ack cycle.
  - o_m1_ack stays 0.
- Simultaneous m0 and m1 requests, both held: grants alternate 0,1,0,1 over 4 transactions, and o_mem_req stays high between the opposite-master grants.
- m1 write addr=0x200 wdata=0x55AA; m1 changes its addr to 0x300 mid-transaction: o_mem_addr stays 0x200 and o_mem_wdata stays 0x55AA until the ack.
- m0 requests continuously alone: IDLE appears for one cycle between transactions, and every transaction is granted to m0.
- Reset asserted in BUSY1 before the ack, then i_mem_ack=1 after reset:
  - All outputs return to their reset values asynchronously.
  - No o_m1_ack pulse; state stays IDLE.
- i_mem_ack=1 in IDLE with no requests: no ack output and o_busy stays 0.
